jt89_mix_seq: RTL and testbench

Sequencer for the JT89 output mixer. It gates the mixer's clocks and releases its reset, which keeps the comb/integrator chain muted and then flushed at power-up and restart. It derives the 1/16 comb enable from the system clock enable and hands mixed samples to the downstream audio sink over a valid/ready handshake, with overrun detection. It sits between the chip core (channel outputs, enables) and the board-level audio path.

---
 rtl/jt89_pkg.sv | 19 +
 rtl/jt89_mix_seq_if.sv | 13 +
 rtl/jt89_mix_div.sv | 44 ++++
 rtl/jt89_mix_seq.sv | 141 ++++++++++++++
 tb/tb_jt89_mix_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/jt89_pkg.sv
// Shared definitions for the JT89 mixer sequencer: FSM encodings and default sizing.
package jt89_pkg;

  typedef enum logic [1:0] {
    JT89_SEQ_IDLE  = 2'd0,
    JT89_SEQ_FLUSH = 2'd1,
    JT89_SEQ_RUN   = 2'd2
  } jt89_seq_e;

  localparam int JT89_BW       = 9;
  localparam int JT89_DIV      = 16;
  localparam int JT89_MUTE_CEN = 4;

  // Width of a down-counter that must hold values 0..max_val.
  function automatic int jt89_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jt89_mix_seq_if.sv
// Sample handoff from the sequencer to the board-level audio sink.
interface jt89_mix_seq_if #(
  parameter int W = 11
) ();

  logic [W-1:0] snd;
  logic         snd_valid;
  logic         snd_ready;

  modport master (output snd, output snd_valid, input snd_ready);
  modport slave  (input snd, input snd_valid, output snd_ready);

endinterface

// File: rtl/jt89_mix_div.sv
// Interpolation phase counter; produces the 1/DIV comb enable and the period-end strobe.
module jt89_mix_div #(
  parameter int DIV = 16,
  localparam int PW = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          hold,
  output logic [PW-1:0] phase,
  output logic          cen_16,
  output logic          last
);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          at_last;

  assign at_last = (phase_q == PW'(DIV - 1));

  // Next phase: parked at 0 while held so a restart opens on a comb pulse.
  always_comb begin
    phase_d = phase_q;
    if (hold) begin
      phase_d = '0;
    end else if (clk_en) begin
      phase_d = at_last ? '0 : phase_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase  = phase_q;
  assign cen_16 = clk_en & ~hold & (phase_q == '0);
  assign last   = clk_en & ~hold & at_last;

endmodule

// File: rtl/jt89_mix_seq.sv
// JT89 mixer sequencer: mixer reset/clock gating, mute-then-flush start-up,
// and a single-entry output holding register with overrun detection.
//
// state | meaning
// IDLE  | mixer held in reset, no comb enables, no sample loads
// FLUSH | mixer running, output forced to zero for MUTE_CEN comb periods
// RUN   | mixer samples passed through to the sink
module jt89_mix_seq
  import jt89_pkg::*;
#(
  parameter int bw       = JT89_BW,
  parameter int DIV      = JT89_DIV,
  parameter int MUTE_CEN = JT89_MUTE_CEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             enable,
  input  logic [bw+1:0]    sound_in,
  output logic             cen_16,
  output logic             mixer_rst,
  output logic             overrun,
  input  logic             clr_ovr,
  jt89_mix_seq_if.master   snd_if
);

  localparam int SW = bw + 2;
  localparam int PW = $clog2(DIV);
  localparam int FW = jt89_cnt_w(MUTE_CEN);

  jt89_seq_e     state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          mixer_rst_q, mixer_rst_d;
  logic [SW-1:0] snd_q, snd_d;
  logic          snd_valid_q, snd_valid_d;
  logic          overrun_q, overrun_d;

  logic [PW-1:0] phase_w;
  logic          cen_w;
  logic          last_w;
  logic          hold_w;
  logic          period_end;
  logic          load;
  logic          load_ok;
  logic          ovr_set;

  assign hold_w = (state_q == JT89_SEQ_IDLE);

  jt89_mix_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .hold   (hold_w),
    .phase  (phase_w),
    .cen_16 (cen_w),
    .last   (last_w)
  );

  assign period_end = clk_en & (phase_w == PW'(DIV - 1));

  // Next-state logic for the FSM, flush counter and output register.
  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    snd_d       = snd_q;
    snd_valid_d = snd_valid_q;
    ovr_set     = 1'b0;
    load        = clk_en & ~hold_w;
    load_ok     = ~snd_valid_q | snd_if.snd_ready;

    case (state_q)
      JT89_SEQ_IDLE: begin
        if (enable) begin
          state_d = JT89_SEQ_FLUSH;
          flush_d = FW'(MUTE_CEN);
        end
      end
      JT89_SEQ_FLUSH: begin
        if (cen_w && flush_q != '0) begin
          flush_d = flush_q - 1'b1;
        end
        // Leave on the period boundary after the last counted comb pulse, so the
        // zero stretch is exactly MUTE_CEN whole periods.
        if (period_end && flush_q == '0) begin
          state_d = JT89_SEQ_RUN;
        end
      end
      JT89_SEQ_RUN: begin
        state_d = JT89_SEQ_RUN;
      end
      default: begin
        state_d = JT89_SEQ_IDLE;
      end
    endcase

    // Stop only at a period boundary so the comb never sees a partial period.
    if (last_w && !enable) begin
      state_d = JT89_SEQ_IDLE;
    end

    if (load) begin
      if (load_ok) begin
        snd_d       = (state_q == JT89_SEQ_RUN) ? sound_in : '0;
        snd_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (snd_valid_q && snd_if.snd_ready) begin
      snd_valid_d = 1'b0;
    end

    overrun_d   = (overrun_q & ~clr_ovr) | ovr_set;
    mixer_rst_d = (state_d == JT89_SEQ_IDLE);
  end

  // Sequencer registers; reset returns the mixer to its muted, held state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= JT89_SEQ_IDLE;
      flush_q     <= '0;
      mixer_rst_q <= 1'b1;
      snd_q       <= '0;
      snd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      mixer_rst_q <= mixer_rst_d;
      snd_q       <= snd_d;
      snd_valid_q <= snd_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cen_16           = cen_w;
  assign mixer_rst        = mixer_rst_q;
  assign overrun          = overrun_q;
  assign snd_if.snd       = snd_q;
  assign snd_if.snd_valid = snd_valid_q;

endmodule

// File: tb/tb_jt89_mix_seq.sv
// Scoreboard bench for the JT89 mixer sequencer (DIV=16, MUTE_CEN=4, clk_en every 4 clks).
module tb_jt89_mix_seq;

  localparam int SW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic          enable = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [SW-1:0] sound_in = '0;
  logic          cen_16;
  logic          mixer_rst;
  logic          overrun;

  jt89_mix_seq_if #(.W(SW)) snd_if ();

  jt89_mix_seq #(.bw(9), .DIV(16), .MUTE_CEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .enable    (enable),
    .sound_in  (sound_in),
    .cen_16    (cen_16),
    .mixer_rst (mixer_rst),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr),
    .snd_if    (snd_if)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [SW-1:0] exp_q[$];

  // Bench-side view of the sequencer: running (FLUSH/RUN), phase of the next
  // clk_en, and number of load attempts since start.
  bit running = 1'b0;
  int phase_m = 0;
  int ld_m    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted transfer is compared against the scoreboard head.
  initial begin
    logic [SW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && snd_if.snd_valid && snd_if.snd_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sample: got %0h expected none at %0t", snd_if.snd, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sample", snd_if.snd, e);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clk_en cycle followed by three idle clks; checks cen_16 in the enable cycle.
  task automatic en_cycle(input logic [SW-1:0] din, input bit clr);
    bit exp_cen;
    sound_in = din;
    clr_ovr  = clr;
    clk_en   = 1'b1;
    exp_cen  = running && (phase_m == 0);
    @(negedge clk);
    chk("cen_16", cen_16, exp_cen);
    @(posedge clk);
    #1;
    clk_en  = 1'b0;
    clr_ovr = 1'b0;
    if (running) begin
      if (phase_m == 15 && !enable) running = 1'b0;
      phase_m = (phase_m + 1) % 16;
      ld_m++;
    end
    repeat (3) tick();
  endtask

  // Load with the sink ready: the first 64 loads after start are muted.
  task automatic ld(input logic [SW-1:0] din);
    if (running) exp_q.push_back((ld_m < 64) ? '0 : din);
    en_cycle(din, 1'b0);
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    running = 1'b1;
    phase_m = 0;
    ld_m    = 0;
    chk("start_mixer_rst", mixer_rst, 1'b0);
  endtask

  logic [SW-1:0] vals[5] = '{11'h155, 11'h2AA, 11'h7FF, 11'h001, 11'h400};

  initial begin
    snd_if.snd_ready = 1'b0;
    clk_en = 1'b1;
    repeat (3) tick();
    chk("rst_mixer_rst", mixer_rst, 1'b1);
    chk("rst_snd_valid", snd_if.snd_valid, 1'b0);
    chk("rst_snd", snd_if.snd, '0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_cen_16", cen_16, 1'b0);
    clk_en = 1'b0;
    rst = 1'b0;
    tick();

    // Idle: no comb pulses, no loads.
    en_cycle(11'h155, 1'b0);
    en_cycle(11'h155, 1'b0);
    chk("idle_snd_valid", snd_if.snd_valid, 1'b0);
    chk("idle_mixer_rst", mixer_rst, 1'b1);

    // Start-up: 64 muted loads, then live samples.
    snd_if.snd_ready = 1'b1;
    start();
    for (int i = 0; i < 70; i++) ld((i < 64) ? 11'h2AA : 11'h155);
    chk("startup_overrun", overrun, 1'b0);
    chk("startup_drained", exp_q.size(), 0);

    // Ready held high with varied data: one transfer per load.
    foreach (vals[i]) begin
      ld(vals[i]);
      chk("hs_valid_pulse", snd_if.snd_valid, 1'b0);
    end
    chk("hs_overrun", overrun, 1'b0);

    // Overrun: sink stalled across further loads.
    snd_if.snd_ready = 1'b0;
    exp_q.push_back(11'h0F0);
    en_cycle(11'h0F0, 1'b0);
    chk("ovr_first_valid", snd_if.snd_valid, 1'b1);
    chk("ovr_first_flag", overrun, 1'b0);
    en_cycle(11'h00F, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_snd_held", snd_if.snd, 11'h0F0);
    en_cycle(11'h0FF, 1'b1);
    chk("ovr_set_wins", overrun, 1'b1);
    chk("ovr_snd_held2", snd_if.snd, 11'h0F0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clear", overrun, 1'b0);

    // Simultaneous consume of the held sample and load of a new one.
    snd_if.snd_ready = 1'b1;
    exp_q.push_back(11'h5A5);
    en_cycle(11'h5A5, 1'b0);
    chk("simul_overrun", overrun, 1'b0);
    chk("simul_drained", exp_q.size(), 0);

    // Enable dropped and restored inside a period: no stop.
    while (phase_m != 5) ld(11'h155);
    enable = 1'b0;
    while (phase_m != 9) ld(11'h123);
    enable = 1'b1;
    while (phase_m != 0) ld(11'h321);
    chk("toggle_mixer_rst", mixer_rst, 1'b0);

    // Enable dropped at phase 5: stop at the phase-15 boundary.
    while (phase_m != 5) ld(11'h0AA);
    enable = 1'b0;
    while (phase_m != 15) ld(11'h0AB);
    chk("stop_pre_mixer_rst", mixer_rst, 1'b0);
    while (running) ld(11'h0AC);
    chk("stop_mixer_rst", mixer_rst, 1'b1);
    chk("stop_drained", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) en_cycle(11'h7AA, 1'b0);
    chk("stop_no_loads", snd_if.snd_valid, 1'b0);

    // Restart, then async reset while a sample is pending.
    start();
    for (int i = 0; i < 66; i++) ld(11'h333);
    snd_if.snd_ready = 1'b0;
    en_cycle(11'h3C3, 1'b0);
    chk("pre_rst_valid", snd_if.snd_valid, 1'b1);
    chk("pre_rst_snd", snd_if.snd, 11'h3C3);
    #2;
    rst = 1'b1;
    clk_en = 1'b1;
    #1;
    chk("arst_snd_valid", snd_if.snd_valid, 1'b0);
    chk("arst_snd", snd_if.snd, '0);
    chk("arst_mixer_rst", mixer_rst, 1'b1);
    chk("arst_cen_16", cen_16, 1'b0);
    #1;
    rst = 1'b0;
    clk_en = 1'b0;
    enable = 1'b0;
    running = 1'b0;
    phase_m = 0;
    tick();
    snd_if.snd_ready = 1'b1;
    en_cycle(11'h155, 1'b0);
    chk("post_rst_valid", snd_if.snd_valid, 1'b0);
    chk("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
